// File: rtl/nfc_ecc_fix.sv
// Read-path ECC correction applier: pops error locations after each decode and
// flips the flagged bit in the page buffer by read-modify-write.
module nfc_ecc_fix #(
    parameter int unsigned DAT_WID    = 16,
    parameter int unsigned ECC_AWID   = 12,
    parameter int unsigned BUF_AWID   = 8,
    parameter int unsigned SECT_WORDS = 256,
    parameter int unsigned MAX_ERR    = 4,
    parameter int unsigned ERR_CWID   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nfc_dat_dir,
    input  logic                ecc_dec_rdy,
    input  logic [ERR_CWID-1:0] ecc_err_num,
    input  logic                ecc_dec_fail,
    output logic                mem_if_rd,
    input  logic [ECC_AWID-1:0] mem_dec_addr,
    output logic                buf_req,
    input  logic                buf_gnt,
    output logic [BUF_AWID-1:0] buf_addr,
    output logic                buf_rd,
    input  logic [DAT_WID-1:0]  buf_rdat,
    output logic                buf_wr,
    output logic [DAT_WID-1:0]  buf_wdat,
    output logic                cor_busy,
    output logic                cor_done,
    output logic                cor_fail,
    output logic [ERR_CWID-1:0] cor_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ERR_CWID-1:0] rem_q, rem_d;
    logic [ECC_AWID-1:0] loc_q, loc_d;
    logic [DAT_WID-1:0]  dat_q, dat_d;
    logic [ERR_CWID-1:0] cnt_q, cnt_d;
    logic                fail_q, fail_d;

    logic head_ok;
    logic too_many;

    assign head_ok  = 32'(mem_dec_addr[ECC_AWID-1:4]) < SECT_WORDS;
    assign too_many = 32'(ecc_err_num) > MAX_ERR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            loc_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            loc_q   <= loc_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        loc_d     = loc_q;
        dat_d     = dat_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        mem_if_rd = 1'b0;
        buf_req   = 1'b0;
        buf_rd    = 1'b0;
        buf_wr    = 1'b0;
        buf_addr  = '0;
        buf_wdat  = '0;
        cor_busy  = 1'b0;
        cor_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ecc_dec_rdy && !nfc_dat_dir) begin
                    rem_d  = ecc_err_num;
                    cnt_d  = '0;
                    fail_d = 1'b0;
                    if (ecc_dec_fail || too_many) begin
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end else if (ecc_err_num == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                cor_busy  = 1'b1;
                mem_if_rd = 1'b1;
                loc_d     = mem_dec_addr;
                rem_d     = rem_q - ERR_CWID'(1);
                // Out-of-sector locations are consumed from the FIFO but never applied.
                if (head_ok)
                    state_d = REQ;
                else
                    state_d = (rem_q == ERR_CWID'(1)) ? DONE : FETCH;
            end
            REQ: begin
                cor_busy = 1'b1;
                buf_req  = 1'b1;
                if (buf_gnt)
                    state_d = RD;
            end
            RD: begin
                cor_busy = 1'b1;
                buf_req  = 1'b1;
                buf_rd   = 1'b1;
                buf_addr = BUF_AWID'(loc_q[ECC_AWID-1:4]);
                state_d  = WAIT;
            end
            WAIT: begin
                cor_busy = 1'b1;
                buf_req  = 1'b1;
                dat_d    = buf_rdat;
                state_d  = WR;
            end
            WR: begin
                cor_busy = 1'b1;
                buf_req  = 1'b1;
                buf_wr   = 1'b1;
                buf_addr = BUF_AWID'(loc_q[ECC_AWID-1:4]);
                buf_wdat = dat_q ^ (DAT_WID'(1) << loc_q[3:0]);
                if (32'(cnt_q) < MAX_ERR)
                    cnt_d = cnt_q + ERR_CWID'(1);
                state_d  = (rem_q != '0) ? FETCH : DONE;
            end
            DONE: begin
                cor_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cor_fail = fail_q;
    assign cor_cnt  = cnt_q;

endmodule

// File: tb/tb_nfc_ecc_fix.sv
// Directed bench for nfc_ecc_fix with a FIFO model, page-buffer model and
// stallable grant; a second instance uses a 16-word sector for range checks.
module tb_nfc_ecc_fix;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, dir, rdy, fail_in, sel;
    logic [3:0]  err_num;
    logic [11:0] head;
    logic        gnt;
    bit   [15:0] rdat_q;

    logic        m_rd0, req0, rd0, wr0, busy0, done0, cfail0;
    logic [7:0]  addr0;
    logic [15:0] wdat0;
    logic [3:0]  cnt0;
    logic        m_rd1, req1, rd1, wr1, busy1, done1, cfail1;
    logic [7:0]  addr1;
    logic [15:0] wdat1;
    logic [3:0]  cnt1;

    nfc_ecc_fix #(.DAT_WID(16), .ECC_AWID(12), .BUF_AWID(8), .SECT_WORDS(256),
                  .MAX_ERR(4), .ERR_CWID(4)) u_dut (
        .clk(clk), .rst(rst), .nfc_dat_dir(dir), .ecc_dec_rdy(rdy & ~sel),
        .ecc_err_num(err_num), .ecc_dec_fail(fail_in), .mem_if_rd(m_rd0),
        .mem_dec_addr(head), .buf_req(req0), .buf_gnt(gnt), .buf_addr(addr0),
        .buf_rd(rd0), .buf_rdat(rdat_q), .buf_wr(wr0), .buf_wdat(wdat0),
        .cor_busy(busy0), .cor_done(done0), .cor_fail(cfail0), .cor_cnt(cnt0)
    );

    nfc_ecc_fix #(.DAT_WID(16), .ECC_AWID(12), .BUF_AWID(8), .SECT_WORDS(16),
                  .MAX_ERR(4), .ERR_CWID(4)) u_dut16 (
        .clk(clk), .rst(rst), .nfc_dat_dir(dir), .ecc_dec_rdy(rdy & sel),
        .ecc_err_num(err_num), .ecc_dec_fail(fail_in), .mem_if_rd(m_rd1),
        .mem_dec_addr(head), .buf_req(req1), .buf_gnt(gnt), .buf_addr(addr1),
        .buf_rd(rd1), .buf_rdat(rdat_q), .buf_wr(wr1), .buf_wdat(wdat1),
        .cor_busy(busy1), .cor_done(done1), .cor_fail(cfail1), .cor_cnt(cnt1)
    );

    logic        s_pop, s_req, s_rd, s_wr, s_busy, s_done, s_fail;
    logic [7:0]  s_addr;
    logic [15:0] s_wdat;
    logic [3:0]  s_cnt;
    assign s_pop  = sel ? m_rd1  : m_rd0;
    assign s_req  = sel ? req1   : req0;
    assign s_rd   = sel ? rd1    : rd0;
    assign s_wr   = sel ? wr1    : wr0;
    assign s_busy = sel ? busy1  : busy0;
    assign s_done = sel ? done1  : done0;
    assign s_fail = sel ? cfail1 : cfail0;
    assign s_addr = sel ? addr1  : addr0;
    assign s_wdat = sel ? wdat1  : wdat0;
    assign s_cnt  = sel ? cnt1   : cnt0;

    // FIFO, buffer and arbiter models
    logic [11:0] fifo [0:63];
    int          qn;
    bit   [15:0] mem [0:255];
    bit   [255:0] wrtn;
    bit   [7:0]  log_addr [0:31];
    bit   [15:0] log_dat [0:31];
    bit   [7:0]  last_rd_addr;
    int          pop_cnt, rd_cnt, wr_cnt, done_cnt, leak_cnt, wait_cnt, stall;

    assign head = fifo[pop_cnt % 64];
    assign gnt  = s_req && (wait_cnt >= stall);

    function automatic logic [15:0] init_word(input logic [7:0] a);
        case (a)
            8'h0A:   return 16'h00FF;
            8'h1F:   return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] rd_word(input logic [7:0] a);
        return wrtn[a] ? mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (s_pop) pop_cnt <= pop_cnt + 1;
        if (s_rd) begin
            rdat_q       <= rd_word(s_addr);
            last_rd_addr <= s_addr;
            rd_cnt       <= rd_cnt + 1;
        end
        if (s_wr) begin
            mem[s_addr]            <= s_wdat;
            wrtn[s_addr]           <= 1'b1;
            log_addr[wr_cnt % 32]  <= s_addr;
            log_dat[wr_cnt % 32]   <= s_wdat;
            wr_cnt                 <= wr_cnt + 1;
        end
        if (s_done) done_cnt <= done_cnt + 1;
        if ((!s_rd && !s_wr && s_addr != 8'h00) || (!s_wr && s_wdat != 16'h0000))
            leak_cnt <= leak_cnt + 1;
        if (rst || !s_req)
            wait_cnt <= 0;
        else if (!gnt)
            wait_cnt <= wait_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] loc);
        fifo[(pop_cnt + qn) % 64] = loc;
        qn++;
    endtask

    task automatic start(input logic [3:0] n, input logic f);
        rdy     = 1'b1;
        err_num = n;
        fail_in = f;
        tick();
        rdy     = 1'b0;
        fail_in = 1'b0;
    endtask

    // lat = cycle index (1 = first cycle after the start edge) at which cor_done is seen
    task automatic wait_done(output int lat);
        lat = 1;
        while (!s_done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    int p0, r0, w0, d0, lat;
    logic seen;

    initial begin
        rst = 1'b1; dir = 1'b0; rdy = 1'b0; err_num = '0; fail_in = 1'b0;
        sel = 1'b0; stall = 0; qn = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {s_pop, s_req, s_rd, s_wr, s_busy, s_done, s_fail}, 0);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_bus", {s_addr, s_wdat}, 0);
        rst = 1'b0;
        tick();

        // encode direction: start ignored
        qn = 0; push(12'h0A3); p0 = pop_cnt;
        dir = 1'b1;
        start(4'd1, 1'b0);
        seen = 1'b0;
        repeat (4) begin seen |= s_busy | s_pop; tick(); end
        chk("dir_ignored", seen, 0);
        chk("dir_pops", pop_cnt - p0, 0);
        dir = 1'b0;

        // single error, grant tied high
        qn = 0; push(12'h0A3); p0 = pop_cnt; r0 = rd_cnt; w0 = wr_cnt;
        start(4'd1, 1'b0);
        chk("single_busy", s_busy, 1);
        wait_done(lat);
        chk("single_lat", lat, 6);
        chk("single_cnt", s_cnt, 1);
        chk("single_fail", s_fail, 0);
        chk("single_pops", pop_cnt - p0, 1);
        chk("single_rds", rd_cnt - r0, 1);
        chk("single_rdaddr", last_rd_addr, 8'h0A);
        chk("single_wr", {log_addr[w0 % 32], log_dat[w0 % 32]}, 24'h0A_00F7);
        tick();
        chk("single_done_pulse", s_done, 0);
        chk("single_idle_busy", s_busy, 0);

        // four errors with 3 stalled grant cycles each
        stall = 3;
        qn = 0; push(12'h013); push(12'h02F); push(12'h010); push(12'h1FF);
        p0 = pop_cnt; w0 = wr_cnt;
        start(4'd4, 1'b0);
        wait_done(lat);
        chk("four_lat", lat, 33);
        chk("four_cnt", s_cnt, 4);
        chk("four_pops", pop_cnt - p0, 4);
        chk("four_nwr", wr_cnt - w0, 4);
        chk("four_w0", {log_addr[(w0 + 0) % 32], log_dat[(w0 + 0) % 32]}, 24'h01_0008);
        chk("four_w1", {log_addr[(w0 + 1) % 32], log_dat[(w0 + 1) % 32]}, 24'h02_8000);
        chk("four_w2", {log_addr[(w0 + 2) % 32], log_dat[(w0 + 2) % 32]}, 24'h01_0009);
        chk("four_w3", {log_addr[(w0 + 3) % 32], log_dat[(w0 + 3) % 32]}, 24'h1F_7FFF);
        tick();
        stall = 0;

        // out-of-range location on the 16-word-sector instance
        sel = 1'b1;
        qn = 0; push(12'h200); push(12'h035); p0 = pop_cnt; w0 = wr_cnt;
        start(4'd2, 1'b0);
        wait_done(lat);
        chk("oor_lat", lat, 7);
        chk("oor_cnt", s_cnt, 1);
        chk("oor_pops", pop_cnt - p0, 2);
        chk("oor_nwr", wr_cnt - w0, 1);
        chk("oor_wr", {log_addr[w0 % 32], log_dat[w0 % 32]}, 24'h03_0020);
        tick();
        sel = 1'b0;
        tick();

        // decoder failure flag
        qn = 0; push(12'h0A3); p0 = pop_cnt; r0 = rd_cnt; w0 = wr_cnt;
        start(4'd2, 1'b1);
        wait_done(lat);
        chk("decfail_lat", lat, 1);
        chk("decfail_fail", s_fail, 1);
        chk("decfail_cnt", s_cnt, 0);
        tick();
        chk("decfail_held", s_fail, 1);
        chk("decfail_noacc", {pop_cnt - p0, rd_cnt - r0, wr_cnt - w0}, 0);

        // too many errors
        start(4'd5, 1'b0);
        wait_done(lat);
        chk("toomany_lat", lat, 1);
        chk("toomany_fail", s_fail, 1);
        tick();
        chk("toomany_noacc", {pop_cnt - p0, rd_cnt - r0, wr_cnt - w0}, 0);

        // valid start clears cor_fail; a second ready while busy is ignored
        qn = 0; push(12'h0B4); push(12'h0A3); p0 = pop_cnt; w0 = wr_cnt;
        start(4'd1, 1'b0);
        chk("clear_fail", s_fail, 0);
        rdy = 1'b1; err_num = 4'd1;
        tick();
        rdy = 1'b0;
        wait_done(lat);
        chk("busy_cnt", s_cnt, 1);
        chk("busy_wr", {log_addr[w0 % 32], log_dat[w0 % 32]}, 24'h0B_0010);
        tick();
        seen = 1'b0;
        repeat (4) begin seen |= s_busy | s_pop; tick(); end
        chk("busy_no_requeue", seen, 0);
        chk("busy_pops", pop_cnt - p0, 1);
        chk("busy_nwr", wr_cnt - w0, 1);

        // reset while in WAIT
        qn = 0; push(12'h0C0); w0 = wr_cnt; d0 = done_cnt;
        start(4'd1, 1'b0);
        lat = 0;
        while (!s_rd && lat < 20) begin tick(); lat++; end
        chk("rstwait_reach_rd", s_rd, 1);
        tick();
        chk("rstwait_in_wait", {s_req, s_rd, s_wr}, 3'b100);
        rst = 1'b1;
        #1;
        chk("rstwait_outs", {s_pop, s_req, s_rd, s_wr, s_busy, s_done, s_fail}, 0);
        chk("rstwait_bus", {s_addr, s_wdat, s_cnt}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rstwait_nowr", wr_cnt - w0, 0);
        chk("rstwait_nodone", done_cnt - d0, 0);

        qn = 0; push(12'h0C1); w0 = wr_cnt;
        start(4'd1, 1'b0);
        wait_done(lat);
        chk("restart_lat", lat, 6);
        chk("restart_cnt", s_cnt, 1);
        chk("restart_wr", {log_addr[w0 % 32], log_dat[w0 % 32]}, 24'h0C_0002);
        tick(); tick();

        chk("bus_zero_when_idle", leak_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
